grant_stream_mux: RTL and testbench

- Consumer side of the round-robin grant protocol: the block that acts on grants.
- Collects N AXI4-Stream-style packet sources and drives the request vector to an external round-robin arbiter (N-wide, registered one-cycle grant pulses).
- Locks onto the granted source for one whole packet (until tlast) and forwards it to a single output stream through a registered output slice.
- Sits between per-channel packet producers and a shared downstream consumer (e.g. DMA or link framer).

---
 rtl/axis_reg_slice.sv | 37 +++
 rtl/grant_stream_mux.sv | 128 ++++++++++++
 tb/tb_grant_stream_mux.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_reg_slice.sv
// Single-register valid/ready pipeline stage. The stage accepts a new word
// when it is empty or when the word it holds leaves in the same cycle. The
// held word stays stable while the output is stalled.
module axis_reg_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_q;
    logic         valid_q;

    assign in_ready  = out_ready | ~valid_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;

    // Load on an input handshake, drain on an output handshake, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            data_q  <= in_data;
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/grant_stream_mux.sv
// Packet-locked N:1 stream mux driven by an external round-robin arbiter.
// Requests go out while idle; a one-cycle grant pulse locks the mux onto one
// source until that source's tlast beat is taken. Beats leave through a
// single register slice with the source index on m_tuser. grant_err flags
// arbiter protocol violations and stays set until reset.
module grant_stream_mux #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]  s_tvalid,
    input  logic [N-1:0]  s_tlast,
    output logic [N-1:0]  s_tready,
    output logic [N-1:0]  arb_req,
    input  logic [N-1:0]  arb_grant,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    output logic [SW-1:0] m_tuser,
    input  logic          m_tready,
    output logic          grant_err
);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    logic          state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [N-1:0]  req_q;
    logic          err_q, err_d;

    logic          cur_valid;
    logic          cur_last;
    logic [DW-1:0] cur_data;
    logic          slice_ready;
    logic          accept;
    logic          grant_any;
    logic          grant_multi;
    logic          grant_unreq;

    // Index of the lowest set bit; a multi-hot grant still resolves to one source.
    function automatic logic [SW-1:0] lsb_index(input logic [N-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = SW'(i);
        end
        return idx;
    endfunction

    assign cur_valid = s_tvalid[sel_q];
    assign cur_last  = s_tlast[sel_q];
    assign cur_data  = s_tdata[sel_q * DW +: DW];
    assign accept    = (state_q == BUSY) & cur_valid & slice_ready;

    assign grant_any   = |arb_grant;
    assign grant_multi = |(arb_grant & (arb_grant - N'(1)));
    assign grant_unreq = |(arb_grant & ~req_q);

    // State, selected source, last request vector and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            req_q   <= arb_req;
            err_q   <= err_d;
        end
    end

    // Next state: lock on a grant while idle, release after the tlast beat.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d = BUSY;
                    sel_d   = lsb_index(arb_grant);
                end
            end
            BUSY: begin
                if (accept && cur_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q | (grant_any & (grant_multi | (state_q == BUSY) | grant_unreq));
    end

    // Outputs: requests only while idle (masked in the grant cycle), ready only
    // to the locked source.
    always_comb begin
        arb_req  = '0;
        s_tready = '0;
        if (!rst) begin
            if (state_q == IDLE) begin
                arb_req = s_tvalid & {N{~grant_any}};
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (sel_q == SW'(i)) s_tready[i] = slice_ready;
                end
            end
        end
    end

    assign grant_err = err_q;

    axis_reg_slice #(
        .W(DW + SW + 1)
    ) u_out_slice (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({sel_q, cur_last, cur_data}),
        .in_valid ((state_q == BUSY) & cur_valid),
        .in_ready (slice_ready),
        .out_data ({m_tuser, m_tlast, m_tdata}),
        .out_valid(m_tvalid),
        .out_ready(m_tready)
    );

endmodule

// File: tb/tb_grant_stream_mux.sv
// Directed bench for grant_stream_mux: queue-driven sources, a registered
// round-robin arbiter model (or manual grants), and an output beat recorder.
module tb_grant_stream_mux;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*DW-1:0] s_tdata = '0;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tlast = '0;
    logic [N-1:0]    s_tready;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    arb_grant;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic [SW-1:0]   m_tuser;
    logic            m_tready = 1'b0;
    logic            grant_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    grant_stream_mux #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .arb_req  (arb_req),
        .arb_grant(arb_grant),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tuser  (m_tuser),
        .m_tready (m_tready),
        .grant_err(grant_err)
    );

    // Sources: each queue entry is {tlast, tdata}; pop on handshake.
    logic [DW:0] src_q [N][$];

    always begin
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        #1;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tlast[i]  = src_q[i][0][DW];
                s_tdata[i*DW +: DW] = src_q[i][0][DW-1:0];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
                s_tdata[i*DW +: DW] = '0;
            end
        end
    end

    // Arbiter model: registered round-robin, one-cycle grant pulses.
    logic         use_arb = 1'b1;
    logic [N-1:0] man_grant = '0;
    logic [N-1:0] arb_q;
    int           rr_last;

    assign arb_grant = use_arb ? arb_q : man_grant;

    always @(posedge clk) begin : arb_model
        bit found;
        int idx;
        found = 0;
        if (rst) begin
            arb_q   <= '0;
            rr_last <= N - 1;
        end else if (!use_arb) begin
            arb_q <= '0;
        end else begin
            arb_q <= '0;
            for (int k = 1; k <= N; k++) begin
                idx = (rr_last + k) % N;
                if (!found && arb_req[idx]) begin
                    found = 1;
                    arb_q   <= 4'(1) << idx;
                    rr_last <= idx;
                end
            end
        end
    end

    // Output recorder.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] u;
        logic          l;
    } beat_t;
    beat_t got[$];

    always @(posedge clk) begin
        if (!rst && m_tvalid && m_tready) got.push_back('{d: m_tdata, u: m_tuser, l: m_tlast});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_tready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({m_tvalid, m_tlast, m_tuser} !== 4'b0) begin
            $display("FAIL reset_mvalid_mlast_muser got=%b want=0000", {m_tvalid, m_tlast, m_tuser});
            n_err++;
        end
        n_vec++;
        if (m_tdata !== 32'h0) begin
            $display("FAIL reset_mtdata got=%h want=00000000", m_tdata);
            n_err++;
        end
        n_vec++;
        if ({s_tready, arb_req} !== 8'h00) begin
            $display("FAIL reset_tready_req got=%b want=00000000", {s_tready, arb_req});
            n_err++;
        end
        n_vec++;
        if (grant_err !== 1'b0) begin
            $display("FAIL reset_grant_err got=%b want=0", grant_err);
            n_err++;
        end
    endtask

    task automatic test_single_source();
        use_arb = 1'b1;
        m_tready = 1'b1;
        got.delete();
        for (int k = 0; k < 3; k++) src_q[1].push_back({(k == 2), 32'hA0 + 32'(k)});
        tick();
        #1;
        n_vec++;
        if (arb_req !== 4'b0010) begin
            $display("FAIL single_req got=%b want=0010", arb_req);
            n_err++;
        end
        tick();
        #1;
        n_vec++;
        if ({arb_grant, arb_req, s_tready} !== 12'b0010_0000_0000) begin
            $display("FAIL single_grant_cycle got=%b want=001000000000",
                     {arb_grant, arb_req, s_tready});
            n_err++;
        end
        tick();
        #1;
        n_vec++;
        if ({s_tready, arb_req} !== 8'b0010_0000) begin
            $display("FAIL single_busy got=%b want=00100000", {s_tready, arb_req});
            n_err++;
        end
        for (int c = 0; c < 20 && got.size() < 3; c++) tick();
        n_vec++;
        if (got.size() != 3) begin
            $display("FAIL single_count got=%0d want=3", got.size());
            n_err++;
        end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            n_vec++;
            if (got[k] !== {32'hA0 + 32'(k), 2'd1, (k == 2)}) begin
                $display("FAIL single_beat%0d got=%h want=%h", k, got[k],
                         {32'hA0 + 32'(k), 2'd1, (k == 2)});
                n_err++;
            end
        end
        tick();
        #1;
        n_vec++;
        if ({grant_err, s_tready} !== 5'b0) begin
            $display("FAIL single_end got=%b want=00000", {grant_err, s_tready});
            n_err++;
        end
    endtask

    task automatic test_contention();
        beat_t exp_b[4];
        use_arb = 1'b1;
        m_tready = 1'b1;
        got.delete();
        src_q[0].push_back({1'b0, 32'hC0});
        src_q[0].push_back({1'b1, 32'hC1});
        src_q[2].push_back({1'b0, 32'hD0});
        src_q[2].push_back({1'b1, 32'hD1});
        // Last grant went to source 1, so round-robin serves 2 before 0.
        exp_b[0] = {32'hD0, 2'd2, 1'b0};
        exp_b[1] = {32'hD1, 2'd2, 1'b1};
        exp_b[2] = {32'hC0, 2'd0, 1'b0};
        exp_b[3] = {32'hC1, 2'd0, 1'b1};
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            tick();
            #1;
            if (s_tready != 0) begin
                n_vec++;
                if (arb_req !== 4'b0) begin
                    $display("FAIL contention_req_in_busy got=%b want=0000", arb_req);
                    n_err++;
                end
            end
        end
        n_vec++;
        if (got.size() != 4) begin
            $display("FAIL contention_count got=%0d want=4", got.size());
            n_err++;
        end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            n_vec++;
            if (got[k] !== exp_b[k]) begin
                $display("FAIL contention_beat%0d got=%h want=%h", k, got[k], exp_b[k]);
                n_err++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]    pat;
        logic          stalled;
        logic [34:0]   hold;
        pat = 4'b1001;
        use_arb = 1'b1;
        got.delete();
        for (int k = 0; k < 4; k++) src_q[1].push_back({(k == 3), 32'hE0 + 32'(k)});
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            m_tready = pat[c % 4];
            #1;
            stalled = m_tvalid && !m_tready;
            hold = {m_tdata, m_tlast, m_tuser};
            if (stalled) begin
                n_vec++;
                if (s_tready !== 4'b0) begin
                    $display("FAIL bp_tready_when_full got=%b want=0000", s_tready);
                    n_err++;
                end
            end
            tick();
            if (stalled) begin
                n_vec++;
                if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== {1'b1, hold}) begin
                    $display("FAIL bp_stable got=%h want=%h",
                             {m_tvalid, m_tdata, m_tlast, m_tuser}, {1'b1, hold});
                    n_err++;
                end
            end
        end
        m_tready = 1'b1;
        n_vec++;
        if (got.size() != 4) begin
            $display("FAIL bp_count got=%0d want=4", got.size());
            n_err++;
        end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            n_vec++;
            if (got[k] !== {32'hE0 + 32'(k), 2'd1, (k == 3)}) begin
                $display("FAIL bp_beat%0d got=%h want=%h", k, got[k],
                         {32'hE0 + 32'(k), 2'd1, (k == 3)});
                n_err++;
            end
        end
        tick();
    endtask

    task automatic test_protocol_errors();
        use_arb = 1'b0;
        m_tready = 1'b1;
        got.delete();
        for (int k = 0; k < 3; k++) src_q[0].push_back({(k == 2), 32'hB0 + 32'(k)});
        tick();
        man_grant = 4'b0101;
        tick();
        man_grant = 4'b0000;
        #1;
        n_vec++;
        if ({grant_err, s_tready} !== 5'b1_0001) begin
            $display("FAIL proto_multi_hot got=%b want=10001", {grant_err, s_tready});
            n_err++;
        end
        tick();
        man_grant = 4'b0001;
        tick();
        man_grant = 4'b0000;
        for (int c = 0; c < 20 && got.size() < 3; c++) tick();
        n_vec++;
        if (got.size() != 3) begin
            $display("FAIL proto_count got=%0d want=3", got.size());
            n_err++;
        end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            n_vec++;
            if (got[k] !== {32'hB0 + 32'(k), 2'd0, (k == 2)}) begin
                $display("FAIL proto_beat%0d got=%h want=%h", k, got[k],
                         {32'hB0 + 32'(k), 2'd0, (k == 2)});
                n_err++;
            end
        end
        tick();
        #1;
        n_vec++;
        if ({grant_err, s_tready} !== 5'b1_0000) begin
            $display("FAIL proto_sticky got=%b want=10000", {grant_err, s_tready});
            n_err++;
        end
        use_arb = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        use_arb = 1'b1;
        m_tready = 1'b1;
        got.delete();
        for (int k = 0; k < 5; k++) src_q[0].push_back({(k == 4), 32'hF0 + 32'(k)});
        for (int c = 0; c < 30 && got.size() < 2; c++) tick();
        m_tready = 1'b0;
        rst = 1'b1;
        src_q[0].delete();
        tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({m_tvalid, m_tlast, m_tuser, s_tready, grant_err} !== 9'b0) begin
            $display("FAIL rstmid_ctrl got=%b want=000000000",
                     {m_tvalid, m_tlast, m_tuser, s_tready, grant_err});
            n_err++;
        end
        n_vec++;
        if (m_tdata !== 32'h0) begin
            $display("FAIL rstmid_mtdata got=%h want=00000000", m_tdata);
            n_err++;
        end
        n_vec++;
        if (got.size() != 2) begin
            $display("FAIL rstmid_truncated got=%0d want=2", got.size());
            n_err++;
        end
        m_tready = 1'b1;
        got.delete();
        src_q[2].push_back({1'b0, 32'h70});
        src_q[2].push_back({1'b1, 32'h71});
        for (int c = 0; c < 20 && got.size() < 2; c++) tick();
        n_vec++;
        if (got.size() != 2) begin
            $display("FAIL rstmid_after_count got=%0d want=2", got.size());
            n_err++;
        end
        for (int k = 0; k < got.size() && k < 2; k++) begin
            n_vec++;
            if (got[k] !== {32'h70 + 32'(k), 2'd2, (k == 1)}) begin
                $display("FAIL rstmid_after_beat%0d got=%h want=%h", k, got[k],
                         {32'h70 + 32'(k), 2'd2, (k == 1)});
                n_err++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int gcyc[$];
        use_arb = 1'b1;
        m_tready = 1'b1;
        got.delete();
        for (int k = 0; k < 3; k++) src_q[3].push_back({1'b1, 32'h90 + 32'(k)});
        for (int c = 0; c < 40 && (got.size() < 3 || gcyc.size() < 3); c++) begin
            tick();
            if (arb_grant[3]) gcyc.push_back(c);
        end
        n_vec++;
        if (got.size() != 3 || gcyc.size() != 3) begin
            $display("FAIL b2b_count got=%0d/%0d want=3/3", got.size(), gcyc.size());
            n_err++;
        end else begin
            for (int k = 1; k < 3; k++) begin
                n_vec++;
                if (gcyc[k] - gcyc[k-1] != 3) begin
                    $display("FAIL b2b_spacing%0d got=%0d want=3", k, gcyc[k] - gcyc[k-1]);
                    n_err++;
                end
            end
        end
        for (int k = 0; k < got.size() && k < 3; k++) begin
            n_vec++;
            if (got[k] !== {32'h90 + 32'(k), 2'd3, 1'b1}) begin
                $display("FAIL b2b_beat%0d got=%h want=%h", k, got[k],
                         {32'h90 + 32'(k), 2'd3, 1'b1});
                n_err++;
            end
        end
        n_vec++;
        if (grant_err !== 1'b0) begin
            $display("FAIL b2b_grant_err got=%b want=0", grant_err);
            n_err++;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_protocol_errors();
        test_reset_mid_packet();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
